i2c_config_sequencer: RTL and testbench
=======================================

I2C_CONFIG_SEQUENCER -- requirements
Module: i2c_config_sequencer

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
  DEV_ADDR        7'h20     7-bit target device address driven on address
  TBL_LEN         6'd32     number of table entries, 1..63
  GAP_CYCLES      16'd2048  idle clk_50 cycles between transactions (covers stop condition)
  TIMEOUT_CYCLES  20'd65536 max clk_50 cycles in REQ before fail
REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
  clk_50       in   1   sole clock
  reset        in   1   asynchronous, active-high reset
  start        in   1   one-cycle pulse; begins sequence
  tbl_addr     out  6   table entry index
  tbl_data     in   16  {sub_address[15:8], data[7:0]} from external ROM
  i2c_de       in   1   byte-done strobe from I2C master (SCL domain)
  i2c_error    in   1   NACK flag from I2C master (SCL domain)
  request      out  1   transaction request to I2C master
  WR           out  1   constant 1 (write)
  length       out  8   constant 8'd1
  address      out  7   constant DEV_ADDR
  sub_address  out  8   register index for current entry
  txReg        out  8   data byte for current entry
  busy         out  1   sequence in progress
  done         out  1   sticky; all entries written
  fail         out  1   sticky; sequence aborted
  fail_index   out  6   tbl_addr of failing entry
REQ-003 SHALL use one clock (clk_50); reset asynchronous, active-high, as decided.

Function
REQ-004 SHALL pass i2c_de and i2c_error through separate 2-flop synchronizers, then a rising-edge detector (de_rise, err_rise).
REQ-005 SHALL implement states IDLE, LOAD, REQ, GAP, DELAY, DONE, FAIL.
REQ-006 IDLE: request=0, busy=0; on start -> LOAD with tbl_addr=0, done=0, fail=0.
REQ-007 LOAD: SHALL wait 2 cycles after tbl_addr change, then register sub_address=tbl_data[15:8], txReg=tbl_data[7:0].
REQ-008 LOAD: if tbl_data[15:8]==8'hFF -> DELAY, else -> REQ.
REQ-009 REQ: request=1; sub_address/txReg SHALL remain stable while request=1.
REQ-010 REQ: on de_rise -> request=0 in the next cycle and -> GAP.
REQ-011 REQ: on err_rise, or timeout counter reaching TIMEOUT_CYCLES-1 -> FAIL, request=0, fail_index=tbl_addr.
REQ-012 err_rise coincident with de_rise SHALL take precedence (FAIL).
REQ-013 GAP: count GAP_CYCLES cycles with request=0.
REQ-014 GAP end: if tbl_addr==TBL_LEN-1 -> DONE, else tbl_addr+1 and -> LOAD.
REQ-015 DELAY: wait txReg*256 cycles (txReg=0 -> zero wait, exits next cycle), no I2C request, then same exit as GAP.
REQ-016 DONE: done=1, busy=0; returns to IDLE next cycle, done remains set until next start.
REQ-017 FAIL: fail=1, busy=0; returns to IDLE next cycle, fail/fail_index held until next start.
REQ-018 busy=1 in LOAD, REQ, GAP, DELAY.
REQ-019 start while busy SHALL be ignored.
REQ-020 Counters SHALL be wide enough for parameters without wrap: 16-bit GAP, 20-bit timeout, 16-bit delay.
REQ-021 Timeout counter SHALL clear on each entry to REQ.
REQ-022 err_rise outside REQ SHALL be ignored.

Reset
REQ-023 reset=1 SHALL immediately force IDLE and clear request, busy, done, fail, fail_index, tbl_addr, sub_address, txReg, counters and synchronizer flops.
REQ-024 reset mid-transaction SHALL drop request asynchronously.
REQ-025 First start SHALL be accepted on the first clk_50 edge after reset deasserts.

Verification
REQ-026 TBL_LEN=3, entries 0x0280/0x0311/0x0422, slave model ACKs -> three requests in order, sub_address 02/03/04, txReg 80/11/22, done=1, fail=0.
REQ-027 Entry 1 NACKed (i2c_error rises) -> fail=1, fail_index=1, request=0, entry 2 never requested.
REQ-028 i2c_de never asserted, TIMEOUT_CYCLES=1000 -> fail=1 exactly 1000 cycles after REQ entry, fail_index=0.
REQ-029 Entry 0xFF04 between two writes -> request low for 1024 cycles plus GAP, no I2C transaction for marker.
REQ-030 reset pulsed during REQ of entry 1 -> request=0 immediately, all outputs at reset values; new start restarts at tbl_addr=0.
REQ-031 start pulsed during GAP -> ignored; sequence completes normally with done=1.

Source files
------------

// File: rtl/i2c_config_sequencer.sv
// i2c_config_sequencer
// Walks a register-initialisation table held in an external ROM and issues one
// single-byte I2C write per entry through an external I2C master.
// Each ROM word is {sub_address, data}. A sub_address of 8'hFF marks a delay
// entry: it waits data*256 clk_50 cycles and generates no bus traffic.
//
// Ports:
//   clk_50               sole clock
//   reset                asynchronous, active-high reset
//   start                one-cycle pulse; starts the table walk when idle
//   tbl_addr             ROM index of the current entry
//   tbl_data             ROM word, sampled two cycles after tbl_addr changes
//   i2c_de, i2c_error    byte-done / NACK strobes from the I2C master (SCL domain)
//   request              transaction request to the I2C master
//   WR, length, address  constant write / one byte / DEV_ADDR
//   sub_address, txReg   register index and data byte of the current entry
//   busy                 sequence in progress
//   done, fail           sticky completion / abort flags, cleared by start
//   fail_index           tbl_addr of the entry that aborted the sequence
module i2c_config_sequencer #(
    parameter logic [6:0]  DEV_ADDR       = 7'h20,
    parameter logic [5:0]  TBL_LEN        = 6'd32,
    parameter logic [15:0] GAP_CYCLES     = 16'd2048,
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd65536
) (
    input  logic        clk_50,
    input  logic        reset,
    input  logic        start,
    output logic [5:0]  tbl_addr,
    input  logic [15:0] tbl_data,
    input  logic        i2c_de,
    input  logic        i2c_error,
    output logic        request,
    output logic        WR,
    output logic [7:0]  length,
    output logic [6:0]  address,
    output logic [7:0]  sub_address,
    output logic [7:0]  txReg,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [5:0]  fail_index
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_REQ   = 3'd2,
        ST_GAP   = 3'd3,
        ST_DELAY = 3'd4,
        ST_DONE  = 3'd5,
        ST_FAIL  = 3'd6
    } state_t;

    state_t      state_r;
    state_t      next_state_s;

    // Synchroniser and edge-history flops for the SCL-domain strobes
    logic        de_meta_r;
    logic        de_sync_r;
    logic        de_prev_r;
    logic        err_meta_r;
    logic        err_sync_r;
    logic        err_prev_r;
    logic        de_rise_s;
    logic        err_rise_s;

    // Per-state cycle counters
    logic        load_cnt_r;
    logic [19:0] to_cnt_r;
    logic [15:0] gap_cnt_r;
    logic [15:0] dly_cnt_r;
    logic [15:0] dly_len_s;

    logic        to_last_s;
    logic        gap_last_s;
    logic        dly_last_s;
    logic        last_entry_s;

    // FSM side-effect strobes
    logic        start_seq_s;
    logic        load_cap_s;
    logic        advance_s;
    logic        fail_hit_s;

    assign WR      = 1'b1;
    assign length  = 8'd1;
    assign address = DEV_ADDR;

    // Two-flop synchronisers followed by a history flop for rising-edge detection
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            de_meta_r  <= 1'b0;
            de_sync_r  <= 1'b0;
            de_prev_r  <= 1'b0;
            err_meta_r <= 1'b0;
            err_sync_r <= 1'b0;
            err_prev_r <= 1'b0;
        end else begin
            de_meta_r  <= i2c_de;
            de_sync_r  <= de_meta_r;
            de_prev_r  <= de_sync_r;
            err_meta_r <= i2c_error;
            err_sync_r <= err_meta_r;
            err_prev_r <= err_sync_r;
        end
    end

    assign de_rise_s  = de_sync_r & ~de_prev_r;
    assign err_rise_s = err_sync_r & ~err_prev_r;

    // A delay entry waits data*256 cycles; data 0 still spends one cycle in DELAY.
    assign dly_len_s    = {txReg, 8'h00};
    assign to_last_s    = (TIMEOUT_CYCLES == 20'd0) || (to_cnt_r == TIMEOUT_CYCLES - 20'd1);
    assign gap_last_s   = (GAP_CYCLES == 16'd0) || (gap_cnt_r == GAP_CYCLES - 16'd1);
    assign dly_last_s   = (dly_len_s == 16'd0) || (dly_cnt_r == dly_len_s - 16'd1);
    assign last_entry_s = (tbl_addr == TBL_LEN - 6'd1);

    // State register
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and per-transition strobes
    always_comb begin
        next_state_s = state_r;
        start_seq_s  = 1'b0;
        load_cap_s   = 1'b0;
        advance_s    = 1'b0;
        fail_hit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_LOAD;
                    start_seq_s  = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // Second LOAD cycle: ROM word for the new index has settled.
                if (load_cnt_r) begin
                    load_cap_s = 1'b1;
                    if (tbl_data[15:8] == 8'hFF) begin
                        next_state_s = ST_DELAY;
                    end else begin
                        next_state_s = ST_REQ;
                    end
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_REQ: begin
                // NACK wins over a simultaneous byte-done.
                if (err_rise_s) begin
                    next_state_s = ST_FAIL;
                    fail_hit_s   = 1'b1;
                end else if (de_rise_s) begin
                    next_state_s = ST_GAP;
                end else if (to_last_s) begin
                    next_state_s = ST_FAIL;
                    fail_hit_s   = 1'b1;
                end else begin
                    next_state_s = ST_REQ;
                end
            end
            ST_GAP: begin
                if (gap_last_s) begin
                    if (last_entry_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_LOAD;
                        advance_s    = 1'b1;
                    end
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            ST_DELAY: begin
                if (dly_last_s) begin
                    if (last_entry_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_LOAD;
                        advance_s    = 1'b1;
                    end
                end else begin
                    next_state_s = ST_DELAY;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            ST_FAIL: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Per-state counters: each is zero on entry and advances while its state holds
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            load_cnt_r <= 1'b0;
            to_cnt_r   <= 20'd0;
            gap_cnt_r  <= 16'd0;
            dly_cnt_r  <= 16'd0;
        end else begin
            load_cnt_r <= (state_r == ST_LOAD) && !load_cap_s;
            to_cnt_r   <= ((state_r == ST_REQ) && (next_state_s == ST_REQ))
                          ? to_cnt_r + 20'd1 : 20'd0;
            gap_cnt_r  <= ((state_r == ST_GAP) && (next_state_s == ST_GAP))
                          ? gap_cnt_r + 16'd1 : 16'd0;
            dly_cnt_r  <= ((state_r == ST_DELAY) && (next_state_s == ST_DELAY))
                          ? dly_cnt_r + 16'd1 : 16'd0;
        end
    end

    // Registered request/busy, decoded from the state being entered
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            request <= 1'b0;
            busy    <= 1'b0;
        end else begin
            request <= (next_state_s == ST_REQ);
            busy    <= (next_state_s == ST_LOAD) || (next_state_s == ST_REQ) ||
                       (next_state_s == ST_GAP)  || (next_state_s == ST_DELAY);
        end
    end

    // Table index and the captured entry; the entry is only rewritten in LOAD,
    // so it is stable for the whole time request is high
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            tbl_addr    <= 6'd0;
            sub_address <= 8'd0;
            txReg       <= 8'd0;
        end else begin
            if (start_seq_s) begin
                tbl_addr <= 6'd0;
            end else if (advance_s) begin
                tbl_addr <= tbl_addr + 6'd1;
            end else begin
                tbl_addr <= tbl_addr;
            end
            if (load_cap_s) begin
                sub_address <= tbl_data[15:8];
                txReg       <= tbl_data[7:0];
            end else begin
                sub_address <= sub_address;
                txReg       <= txReg;
            end
        end
    end

    // Sticky status flags, cleared only by an accepted start
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            done       <= 1'b0;
            fail       <= 1'b0;
            fail_index <= 6'd0;
        end else begin
            if (start_seq_s) begin
                done       <= 1'b0;
                fail       <= 1'b0;
                fail_index <= 6'd0;
            end else if (fail_hit_s) begin
                fail       <= 1'b1;
                fail_index <= tbl_addr;
            end else if (next_state_s == ST_DONE) begin
                done       <= 1'b1;
            end else begin
                done       <= done;
                fail       <= fail;
                fail_index <= fail_index;
            end
        end
    end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
`timescale 1ns/1ps
module tb_i2c_config_sequencer;

    localparam logic [6:0]  P_DEV = 7'h2A;
    localparam logic [5:0]  P_LEN = 6'd3;
    localparam logic [15:0] P_GAP = 16'd16;
    localparam logic [19:0] P_TMO = 20'd1000;

    logic        clk_50 = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  tbl_addr;
    logic [15:0] tbl_data;
    logic        i2c_de;
    logic        i2c_error;
    logic        request;
    logic        WR;
    logic [7:0]  length;
    logic [6:0]  address;
    logic [7:0]  sub_address;
    logic [7:0]  txReg;
    logic        busy;
    logic        done;
    logic        fail;
    logic [5:0]  fail_index;

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;

    logic [15:0] rom [0:63];

    // slave behaviour: 1-based request number that gets NACK / NACK+ACK / silence
    int nack_at = 0, coin_at = 0, mute_from = 0, req_num = 0;
    int slv_lat = 0, slv_hold = 0;
    bit slv_busy = 1'b0;

    // monitor records
    logic [15:0] obs_q[$];
    int          rise_q[$];
    int          fall_q[$];
    int          stab_viol = 0;
    int          fail_cyc  = 0;
    logic        prev_req  = 1'b0;
    logic        prev_fail = 1'b0;
    logic [15:0] held      = 16'd0;

    // reference model results
    logic [15:0] exp_q[$];
    int          exp_pos[$];
    bit          exp_fail;
    int          exp_idx;

    i2c_config_sequencer #(
        .DEV_ADDR(P_DEV), .TBL_LEN(P_LEN), .GAP_CYCLES(P_GAP), .TIMEOUT_CYCLES(P_TMO)
    ) dut (
        .clk_50(clk_50), .reset(reset), .start(start), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .i2c_de(i2c_de), .i2c_error(i2c_error),
        .request(request), .WR(WR), .length(length), .address(address),
        .sub_address(sub_address), .txReg(txReg), .busy(busy), .done(done),
        .fail(fail), .fail_index(fail_index)
    );

    always #10 clk_50 = ~clk_50;

    always @(posedge clk_50) cyc <= cyc + 1;

    // synchronous ROM, one cycle read latency
    always @(posedge clk_50) tbl_data <= rom[tbl_addr];

    // monitor: transactions, request edges, stability while requesting, fail rise time
    always @(negedge clk_50) begin
        if (request === 1'b1 && prev_req === 1'b0) begin
            obs_q.push_back({sub_address, txReg});
            rise_q.push_back(cyc);
        end
        if (request === 1'b0 && prev_req === 1'b1) fall_q.push_back(cyc);
        if (request === 1'b1 && prev_req === 1'b1 && {sub_address, txReg} !== held) stab_viol++;
        if (request === 1'b1) held = {sub_address, txReg};
        if (fail === 1'b1 && prev_fail === 1'b0) fail_cyc = cyc;
        prev_req  = request;
        prev_fail = fail;
    end

    // I2C master / slave model: answers each request after a random latency
    initial begin
        i2c_de    = 1'b0;
        i2c_error = 1'b0;
        forever begin
            @(negedge clk_50);
            if (slv_hold > 0) begin
                slv_hold--;
                if (slv_hold == 0) begin
                    i2c_de    = 1'b0;
                    i2c_error = 1'b0;
                end
            end
            if (request !== 1'b1) begin
                slv_busy = 1'b0;
            end else if (!slv_busy) begin
                slv_busy = 1'b1;
                req_num++;
                slv_lat = $urandom_range(12, 2);
            end else if (slv_lat > 0) begin
                slv_lat--;
                if (slv_lat == 0 && !(mute_from != 0 && req_num >= mute_from)) begin
                    if (req_num == nack_at) begin
                        i2c_error = 1'b1;
                    end else if (req_num == coin_at) begin
                        i2c_error = 1'b1;
                        i2c_de    = 1'b1;
                    end else begin
                        i2c_de = 1'b1;
                    end
                    slv_hold = 4;
                end
            end
        end
    end

    // Model: which entries reach the bus, and where the walk stops on failure
    task automatic build_model();
        int k = 0;
        exp_q.delete();
        exp_pos.delete();
        exp_fail = 1'b0;
        exp_idx  = 0;
        for (int i = 0; i < int'(P_LEN); i++) begin
            if (rom[i][15:8] != 8'hFF) begin
                exp_q.push_back(rom[i]);
                exp_pos.push_back(i);
                k++;
                if (k == nack_at || k == coin_at || k == mute_from) begin
                    exp_fail = 1'b1;
                    exp_idx  = i;
                    break;
                end
            end
        end
    endtask

    // Model: request-low cycles between writes at table positions a and b
    function automatic int exp_low(int a, int b);
        int t = int'(P_GAP) + 2;
        for (int m = a + 1; m < b; m++) begin
            t += 2 + ((rom[m][7:0] == 8'd0) ? 1 : int'(rom[m][7:0]) * 256);
        end
        return t;
    endfunction

    task automatic clear_obs();
        obs_q.delete();
        rise_q.delete();
        fall_q.delete();
        stab_viol = 0;
        req_num   = 0;
        fail_cyc  = 0;
    endtask

    task automatic set_basic_rom();
        rom[0] = 16'h0280;
        rom[1] = 16'h0311;
        rom[2] = 16'h0422;
    endtask

    task automatic set_random_rom();
        for (int i = 0; i < 3; i++) rom[i] = {8'($urandom_range(254, 0)), 8'($urandom_range(255, 0))};
    endtask

    task automatic run_seq(output bit tmo);
        tmo = 1'b1;
        @(negedge clk_50);
        start = 1'b1;
        @(negedge clk_50);
        start = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if (done === 1'b1 || fail === 1'b1) begin
                tmo = 1'b0;
                break;
            end
            @(negedge clk_50);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk_50);
        n_vec++;
        if ({request, busy, done, fail} !== 4'b0000 || tbl_addr !== 6'd0 || fail_index !== 6'd0 ||
            sub_address !== 8'd0 || txReg !== 8'd0) begin
            n_mis++;
            $display("FAIL reset_state: req=%b busy=%b done=%b fail=%b addr=%h fidx=%h sub=%h tx=%h, want all zero",
                     request, busy, done, fail, tbl_addr, fail_index, sub_address, txReg);
        end
        n_vec++;
        if (WR !== 1'b1 || length !== 8'd1 || address !== P_DEV) begin
            n_mis++;
            $display("FAIL constants: WR=%b length=%h address=%h, want 1/01/%h", WR, length, address, P_DEV);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk_50);
        n_vec++;
        if (busy !== 1'b0 || request !== 1'b0) begin
            n_mis++;
            $display("FAIL idle_no_start: busy=%b req=%b, want 0/0", busy, request);
        end
    endtask

    task automatic test_basic_ack();
        bit tmo;
        for (int it = 0; it < 5; it++) begin
            if (it == 0) begin
                set_basic_rom();
            end else begin
                set_random_rom();
                if ($urandom_range(3, 0) == 0) rom[1] = {8'hFF, 8'($urandom_range(1, 0))};
            end
            nack_at = 0; coin_at = 0; mute_from = 0;
            build_model();
            clear_obs();
            run_seq(tmo);
            repeat (3) @(negedge clk_50);
            n_vec++;
            if (tmo !== 1'b0 || done !== 1'b1 || fail !== 1'b0 || busy !== 1'b0 || request !== 1'b0) begin
                n_mis++;
                $display("FAIL ack_status it%0d: tmo=%b done=%b fail=%b busy=%b req=%b, want 0/1/0/0/0",
                         it, tmo, done, fail, busy, request);
            end
            n_vec++;
            if (obs_q.size() != exp_q.size()) begin
                n_mis++;
                $display("FAIL ack_count it%0d: got %0d writes, want %0d", it, obs_q.size(), exp_q.size());
            end
            for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
                n_vec++;
                if (obs_q[j] !== exp_q[j]) begin
                    n_mis++;
                    $display("FAIL ack_write it%0d #%0d: got %h, want %h", it, j, obs_q[j], exp_q[j]);
                end
            end
            for (int j = 0; j + 1 < exp_q.size() && j + 1 < rise_q.size() && j < fall_q.size(); j++) begin
                n_vec++;
                if (rise_q[j+1] - fall_q[j] != exp_low(exp_pos[j], exp_pos[j+1])) begin
                    n_mis++;
                    $display("FAIL ack_gap it%0d #%0d: got %0d low cycles, want %0d", it, j,
                             rise_q[j+1] - fall_q[j], exp_low(exp_pos[j], exp_pos[j+1]));
                end
            end
            n_vec++;
            if (stab_viol != 0) begin
                n_mis++;
                $display("FAIL ack_stable it%0d: %0d changes while requesting, want 0", it, stab_viol);
            end
        end
    endtask

    task automatic test_nack();
        bit tmo;
        for (int it = 0; it < 5; it++) begin
            nack_at = 0; coin_at = 0; mute_from = 0;
            if (it == 0) begin
                set_basic_rom();
                nack_at = 2;
            end else if (it == 1) begin
                set_basic_rom();
                coin_at = 1;
            end else begin
                set_random_rom();
                if ($urandom_range(1, 0) == 1) nack_at = $urandom_range(3, 1);
                else coin_at = $urandom_range(3, 1);
            end
            build_model();
            clear_obs();
            run_seq(tmo);
            repeat (3) @(negedge clk_50);
            n_vec++;
            if (tmo !== 1'b0 || fail !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || request !== 1'b0) begin
                n_mis++;
                $display("FAIL nack_status it%0d: tmo=%b fail=%b done=%b busy=%b req=%b, want 0/1/0/0/0",
                         it, tmo, fail, done, busy, request);
            end
            n_vec++;
            if (fail_index !== 6'(exp_idx)) begin
                n_mis++;
                $display("FAIL nack_index it%0d: got %0d, want %0d", it, fail_index, exp_idx);
            end
            n_vec++;
            if (obs_q.size() != exp_q.size()) begin
                n_mis++;
                $display("FAIL nack_count it%0d: got %0d writes, want %0d", it, obs_q.size(), exp_q.size());
            end
            for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
                n_vec++;
                if (obs_q[j] !== exp_q[j]) begin
                    n_mis++;
                    $display("FAIL nack_write it%0d #%0d: got %h, want %h", it, j, obs_q[j], exp_q[j]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit tmo;
        set_basic_rom();
        nack_at = 0; coin_at = 0; mute_from = 1;
        clear_obs();
        run_seq(tmo);
        repeat (3) @(negedge clk_50);
        n_vec++;
        if (tmo !== 1'b0 || fail !== 1'b1 || done !== 1'b0 || request !== 1'b0 || fail_index !== 6'd0) begin
            n_mis++;
            $display("FAIL timeout_status: tmo=%b fail=%b done=%b req=%b fidx=%0d, want 0/1/0/0/0",
                     tmo, fail, done, request, fail_index);
        end
        n_vec++;
        if (obs_q.size() != 1) begin
            n_mis++;
            $display("FAIL timeout_count: got %0d writes, want 1", obs_q.size());
        end
        if (rise_q.size() > 0) begin
            n_vec++;
            if (fail_cyc - rise_q[0] != int'(P_TMO)) begin
                n_mis++;
                $display("FAIL timeout_cycles: got %0d, want %0d", fail_cyc - rise_q[0], int'(P_TMO));
            end
        end
        mute_from = 0;
    endtask

    task automatic test_delay_marker();
        bit tmo;
        int n;
        for (int it = 0; it < 3; it++) begin
            n = (it == 0) ? 4 : (it == 1) ? 0 : int'($urandom_range(3, 1));
            rom[0] = 16'h0280;
            rom[1] = {8'hFF, 8'(n)};
            rom[2] = 16'h0422;
            nack_at = 0; coin_at = 0; mute_from = 0;
            build_model();
            clear_obs();
            run_seq(tmo);
            repeat (3) @(negedge clk_50);
            n_vec++;
            if (tmo !== 1'b0 || done !== 1'b1 || fail !== 1'b0) begin
                n_mis++;
                $display("FAIL delay_status n=%0d: tmo=%b done=%b fail=%b, want 0/1/0", n, tmo, done, fail);
            end
            n_vec++;
            if (obs_q.size() != 2 || obs_q[0] !== 16'h0280 || obs_q[1] !== 16'h0422) begin
                n_mis++;
                $display("FAIL delay_writes n=%0d: got %0d writes, want 2 (0280, 0422)", n, obs_q.size());
            end
            if (rise_q.size() > 1 && fall_q.size() > 0) begin
                n_vec++;
                if (rise_q[1] - fall_q[0] != exp_low(0, 2)) begin
                    n_mis++;
                    $display("FAIL delay_low n=%0d: got %0d low cycles, want %0d", n,
                             rise_q[1] - fall_q[0], exp_low(0, 2));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 1'b0;
        bit tmo = 1'b1;
        set_basic_rom();
        nack_at = 0; coin_at = 0; mute_from = 2;
        clear_obs();
        @(negedge clk_50);
        start = 1'b1;
        @(negedge clk_50);
        start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_50);
            if (req_num == 2 && request === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        n_vec++;
        if (hit !== 1'b1) begin
            n_mis++;
            $display("FAIL rmid_reach: entry 1 request seen=%b, want 1", hit);
        end
        #3 reset = 1'b1;
        #1;
        n_vec++;
        if ({request, busy, done, fail} !== 4'b0000 || tbl_addr !== 6'd0 || fail_index !== 6'd0 ||
            sub_address !== 8'd0 || txReg !== 8'd0) begin
            n_mis++;
            $display("FAIL rmid_async: req=%b busy=%b done=%b fail=%b addr=%h sub=%h tx=%h, want all zero",
                     request, busy, done, fail, tbl_addr, sub_address, txReg);
        end
        @(negedge clk_50);
        mute_from = 0;
        build_model();
        clear_obs();
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk_50);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_mis++;
            $display("FAIL rmid_first_start: busy=%b, want 1", busy);
        end
        for (int i = 0; i < 8000; i++) begin
            if (done === 1'b1 || fail === 1'b1) begin
                tmo = 1'b0;
                break;
            end
            @(negedge clk_50);
        end
        n_vec++;
        if (tmo !== 1'b0 || done !== 1'b1 || fail !== 1'b0 || obs_q.size() != 3) begin
            n_mis++;
            $display("FAIL rmid_restart: tmo=%b done=%b fail=%b writes=%0d, want 0/1/0/3",
                     tmo, done, fail, obs_q.size());
        end
        for (int j = 0; j < 3 && j < obs_q.size(); j++) begin
            n_vec++;
            if (obs_q[j] !== exp_q[j]) begin
                n_mis++;
                $display("FAIL rmid_write #%0d: got %h, want %h", j, obs_q[j], exp_q[j]);
            end
        end
    endtask

    task automatic test_start_during_gap();
        bit tmo = 1'b1;
        set_random_rom();
        nack_at = 0; coin_at = 0; mute_from = 0;
        build_model();
        clear_obs();
        @(negedge clk_50);
        start = 1'b1;
        @(negedge clk_50);
        start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (fall_q.size() > 0) break;
            @(negedge clk_50);
        end
        // start and a stray NACK edge, both inside the first GAP
        repeat (3) @(negedge clk_50);
        start = 1'b1;
        @(negedge clk_50);
        start = 1'b0;
        @(negedge clk_50);
        i2c_error = 1'b1;
        repeat (4) @(negedge clk_50);
        i2c_error = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if (done === 1'b1 || fail === 1'b1) begin
                tmo = 1'b0;
                break;
            end
            @(negedge clk_50);
        end
        n_vec++;
        if (tmo !== 1'b0 || done !== 1'b1 || fail !== 1'b0 || obs_q.size() != exp_q.size()) begin
            n_mis++;
            $display("FAIL gapstart_status: tmo=%b done=%b fail=%b writes=%0d, want 0/1/0/%0d",
                     tmo, done, fail, obs_q.size(), exp_q.size());
        end
        for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
            n_vec++;
            if (obs_q[j] !== exp_q[j]) begin
                n_mis++;
                $display("FAIL gapstart_write #%0d: got %h, want %h", j, obs_q[j], exp_q[j]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
        test_reset();
        test_basic_ack();
        test_nack();
        test_timeout();
        test_delay_marker();
        test_reset_mid();
        test_start_during_gap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
